// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared encodings and constants for the nibble-serial adder controller.
// State value 2'b11 is never produced; the controller treats it as IDLE.
package adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit add slice with carry-in/out.
// The controller time-multiplexes it across all nibbles of an operand.
module nibble_add_slice
    import adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] w_sum5;

    assign w_sum5 = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};
    assign s      = w_sum5[NIBBLE_W-1:0];
    assign cout   = w_sum5[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice, LS nibble first, carry held in a register.
// Operands enter on a valid/ready accept; the result is held in DONE until consumed.
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16  // must be a multiple of 4 and at least 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a_sh;
    logic [WIDTH-1:0]    r_b_sh;
    logic [WIDTH-1:0]    r_sum_sh;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_step;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_carry;
    logic [WIDTH-1:0]    w_sum_shift;

    nibble_add_slice u_slice (
        .x    (r_a_sh[NIBBLE_W-1:0]),
        .y    (r_b_sh[NIBBLE_W-1:0]),
        .cin  (r_carry),
        .s    (w_nib_sum),
        .cout (w_nib_carry)
    );

    // New nibble enters at the top so after NIB steps nibble 0 sits at the bottom.
    always_comb begin
        w_sum_shift = r_sum_sh >> NIBBLE_W;
        w_sum_shift[WIDTH-1 -: NIBBLE_W] = w_nib_sum;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                // in_ready is gated by rst_n so nothing is accepted while reset is held.
                w_in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= b;
                r_carry <= ci;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_a_sh   <= r_a_sh >> NIBBLE_W;
                r_b_sh   <= r_b_sh >> NIBBLE_W;
                r_sum_sh <= w_sum_shift;
                r_carry  <= w_nib_carry;
                if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign sum       = r_sum_sh;
    assign co        = r_carry;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
// Reference: full-width {co,sum} = a + b + ci computed directly.
module tb_nibble_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         co;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                          input bit corrupt, input int stall);
        logic [W:0]   exp;
        logic [W-1:0] held_sum;
        logic         held_co;
        int           lat;
        exp = golden(ta, tb_, tci);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        ci        = tci;
        out_ready = 1'b0;
        check_eq("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (corrupt) begin
                a  = W'($urandom);
                b  = W'($urandom);
                ci = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, NIB);
        check_eq("sum", sum, exp[W-1:0]);
        check_eq("co", co, exp[W]);
        check_eq("busy_done", busy, 1);
        held_sum = sum;
        held_co  = co;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = 16'h0F0F;
            b        = W'($urandom);
            @(posedge clk); #1;
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_sum", sum, held_sum);
            check_eq("stall_co", co, held_co);
            check_eq("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        int         nacc;
        int         last_acc;
        bit         acc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_co", co, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 10);
        run_op(16'h0A0A, 16'h0505, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 0);

        // Reset during the second RUN cycle
        in_valid = 1'b1;
        a = 16'h7777;
        b = 16'h9999;
        ci = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_sum", sum, 0);
        check_eq("mid_rst_co", co, 0);
        check_eq("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        check_eq("mid_rst_hold_ready", in_ready, 0);
        check_eq("mid_rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", in_ready, 1);
        run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 0);

        // Random operands with random consumer stalls
        for (int k = 0; k < 20; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Throughput with in_valid and out_ready held high
        a = 16'hFFF0;
        b = 16'h0011;
        ci = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        nacc = 0;
        last_acc = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (out_valid) begin
                check_eq("tp_expected_pending", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_eq("tp_sum", sum, e[W-1:0]);
                    check_eq("tp_co", co, e[W]);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(golden(a, b, ci));
                if (last_acc >= 0) check_eq("tp_interval", cyc - last_acc, NIB + 2);
                last_acc = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                a  = a + 16'h1111;
                b  = b + 16'h0101;
                ci = ~ci;
                if (nacc == 6) in_valid = 1'b0;
            end
            if (nacc == 6 && q.size() == 0) break;
        end
        check_eq("tp_accepts", nacc, 6);
        check_eq("tp_drained", q.size(), 0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
